// File: rtl/vga_timing_gen.sv
// vga_timing_gen: waits for a stable PLL lock, then produces a pixel strobe and
// registered VGA sync/active/coordinate outputs for the pixel at (h,v).
module vga_timing_gen #(
    parameter int PIX_DIV     = 10,
    parameter int LOCK_CYCLES = 256,
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter bit SYNC_POL    = 1'b0
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       locked,
    output logic       running,
    output logic       pix_en,
    output logic       hsync,
    output logic       vsync,
    output logic       active,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       frame_start
);
    localparam int LW = $clog2(LOCK_CYCLES + 1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);
    localparam logic [4:0] DIV_LAST = 5'(PIX_DIV - 1);
    localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HA = 10'(H_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VA = 10'(V_ACTIVE);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic WAIT_LOCK = 1'b0;
    localparam logic RUN = 1'b1;

    logic          state, state_n;
    logic [LW-1:0] lock_cnt, lock_n;
    logic [4:0]    div, div_n;
    logic [9:0]    h, v, h_n, v_n;
    logic          run_n, pix_n, v_vis, act_n, hs_on, vs_on;

    // Next pixel position; outputs are decoded from it so they land with the counters.
    always_comb begin
        state_n = WAIT_LOCK;
        lock_n  = '0;
        div_n   = '0;
        h_n     = '0;
        v_n     = '0;
        if (state == WAIT_LOCK) begin
            state_n = (locked && lock_cnt == LOCK_LAST) ? RUN : WAIT_LOCK;
            lock_n  = (locked && state_n == WAIT_LOCK) ? lock_cnt + 1'b1 : '0;
        end else if (locked) begin
            state_n = RUN;
            div_n   = (div == DIV_LAST) ? '0 : div + 1'b1;
            h_n     = (div != DIV_LAST) ? h : (h == H_LAST) ? '0 : h + 1'b1;
            v_n     = (div != DIV_LAST || h != H_LAST) ? v : (v == V_LAST) ? '0 : v + 1'b1;
        end
    end

    assign run_n = (state_n == RUN);
    assign pix_n = run_n && div_n == DIV_LAST;
    assign v_vis = run_n && v_n < VA;
    assign act_n = v_vis && h_n < HA;
    assign hs_on = run_n && h_n >= HS_BEG && h_n < HS_END;
    assign vs_on = run_n && v_n >= VS_BEG && v_n < VS_END;

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state       <= WAIT_LOCK;
            lock_cnt    <= '0;
            div         <= '0;
            h           <= '0;
            v           <= '0;
            pix_en      <= 1'b0;
            active      <= 1'b0;
            x           <= '0;
            y           <= '0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            frame_start <= 1'b0;
        end else begin
            state       <= state_n;
            lock_cnt    <= lock_n;
            div         <= div_n;
            h           <= h_n;
            v           <= v_n;
            pix_en      <= pix_n;
            active      <= act_n;
            x           <= act_n ? h_n : '0;
            y           <= v_vis ? v_n : '0;
            hsync       <= hs_on ? SYNC_POL : ~SYNC_POL;
            vsync       <= vs_on ? SYNC_POL : ~SYNC_POL;
            frame_start <= pix_n && h_n == '0 && v_n == '0;
        end
    end

    assign running = (state == RUN);
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: small-timing directed bench with a cycle model feeding an
// expected-output queue that is popped and compared after every clock edge.
module tb_vga_timing_gen;
    localparam int PD = 2;
    localparam int LC = 4;
    localparam int HT = 8;
    localparam int VT = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       locked = 1'b1;
    logic       running, pix_en, hsync, vsync, active, frame_start;
    logic [9:0] x, y;

    int          checks = 0;
    int          errors = 0;
    logic [25:0] exp_q[$];
    logic        m_run = 1'b0;
    int          m_cnt = 0, m_div = 0, m_h = 0, m_v = 0;

    vga_timing_gen #(
        .PIX_DIV(PD), .LOCK_CYCLES(LC),
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b0)
    ) dut (
        .clock_in(clk), .reset(reset), .locked(locked), .running(running),
        .pix_en(pix_en), .hsync(hsync), .vsync(vsync), .active(active),
        .x(x), .y(y), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic advance(input logic r, input logic l);
        if (r) begin
            m_run = 1'b0; m_cnt = 0; m_div = 0; m_h = 0; m_v = 0;
        end else if (!m_run) begin
            m_cnt = l ? m_cnt + 1 : 0;
            if (m_cnt == LC) begin
                m_run = 1'b1; m_cnt = 0; m_div = 0; m_h = 0; m_v = 0;
            end
        end else if (!l) begin
            m_run = 1'b0; m_cnt = 0; m_div = 0; m_h = 0; m_v = 0;
        end else if (m_div == PD - 1) begin
            m_div = 0;
            m_h = (m_h + 1) % HT;
            if (m_h == 0) m_v = (m_v + 1) % VT;
        end else begin
            m_div++;
        end
    endtask

    function automatic logic [25:0] predict();
        logic       pe, act;
        logic [9:0] ex, ey;
        pe  = m_run && m_div == PD - 1;
        act = m_run && m_h < 4 && m_v < 3;
        ex  = act ? 10'(m_h) : 10'd0;
        ey  = (m_run && m_v < 3) ? 10'(m_v) : 10'd0;
        return {m_run, pe, !(m_run && (m_h == 5 || m_h == 6)), !(m_run && m_v == 4),
                act, pe && m_h == 0 && m_v == 0, ex, ey};
    endfunction

    task automatic step(input logic r, input logic l);
        reset = r;
        locked = l;
        advance(r, l);
        exp_q.push_back(predict());
        @(posedge clk);
        #1;
        chk("scoreboard", {6'b0, running, pix_en, hsync, vsync, active, frame_start, x, y},
            {6'b0, exp_q.pop_front()});
    endtask

    initial begin
        int n_pe, n_act, n_hs, n_fs, n_vs, n_y, xi;
        // 1: reset with locked high, then 4 samples to RUN
        repeat (3) step(1'b1, 1'b1);
        chk("rst_running", 32'(running), 0);
        chk("rst_syncs", {30'b0, hsync, vsync}, 32'b11);
        chk("rst_xy", {12'b0, x, y}, 0);
        chk("rst_strobes", {29'b0, pix_en, active, frame_start}, 0);
        repeat (3) step(1'b0, 1'b1);
        chk("lock3_running", 32'(running), 0);
        step(1'b0, 1'b1);
        chk("lock4_running", 32'(running), 1);
        // 2: glitch in the lock pattern restarts the count
        step(1'b1, 1'b1);
        step(1'b0, 1'b1); step(1'b0, 1'b1); step(1'b0, 1'b1); step(1'b0, 1'b0);
        step(1'b0, 1'b1); step(1'b0, 1'b1); step(1'b0, 1'b1);
        chk("glitch_3_running", 32'(running), 0);
        step(1'b0, 1'b1);
        chk("glitch_4_running", 32'(running), 1);
        // 3: one line of 16 clocks
        n_pe = 0; n_act = 0; n_hs = 0; xi = 0;
        for (int i = 0; i < 16; i++) begin
            n_pe += int'(pix_en);
            n_act += int'(active);
            n_hs += int'(!hsync);
            if (pix_en && active) begin
                chk("x_seq", 32'(x), 32'(xi));
                xi++;
            end
            step(1'b0, 1'b1);
        end
        chk("line_pix_en", n_pe, 8);
        chk("line_active", n_act, 8);
        chk("line_hsync_low", n_hs, 4);
        chk("line_x_count", xi, 4);
        // 4: one full frame of 96 clocks
        n_fs = 0; n_vs = 0; n_y = 0;
        for (int i = 0; i < 96; i++) begin
            n_fs += int'(frame_start);
            n_vs += int'(!vsync);
            n_y += int'(y != 0);
            step(1'b0, 1'b1);
        end
        chk("frame_start_count", n_fs, 1);
        chk("frame_vsync_low", n_vs, 16);
        chk("frame_y_nonzero", n_y, 32);
        // 5: lock loss at h=2,v=1
        for (int i = 0; i < 200 && !(m_h == 2 && m_v == 1); i++) step(1'b0, 1'b1);
        chk("reach_h2v1", {12'b0, x, y}, {12'b0, 10'd2, 10'd1});
        step(1'b0, 1'b0);
        chk("unlock_running", 32'(running), 0);
        chk("unlock_syncs", {30'b0, hsync, vsync}, 32'b11);
        chk("unlock_xy", {12'b0, x, y}, 0);
        repeat (3) step(1'b0, 1'b1);
        chk("relock3_running", 32'(running), 0);
        step(1'b0, 1'b1);
        chk("relock4_running", 32'(running), 1);
        chk("relock_origin", {11'b0, active, x, y}, {11'b0, 1'b1, 20'b0});
        step(1'b0, 1'b1);
        chk("relock_frame_start", {30'b0, pix_en, frame_start}, 32'b11);
        // 6: reset mid-line
        repeat (5) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        chk("midreset_running", 32'(running), 0);
        chk("midreset_outs", {26'b0, pix_en, active, frame_start, hsync, vsync, 1'b0}, 32'b000110);
        repeat (3) step(1'b0, 1'b1);
        chk("rerun3_running", 32'(running), 0);
        step(1'b0, 1'b1);
        chk("rerun4_running", 32'(running), 1);
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
